// File: rtl/branch_resolution_unit_if.sv
// Decode-to-fetch branch resolution bus: branch info and hazard status in,
// fetch address, flush, decode hold and taken statistics out.
interface branch_resolution_unit_if;
    logic        stall_in;
    logic        branch_valid;
    logic [1:0]  branch_type;
    logic [31:0] branch_target;
    logic        operands_ready;
    logic        inputs_not_equal;
    logic [31:0] pc;
    logic        flush;
    logic        branch_stall;
    logic [15:0] taken_count;

    // Pipeline side: supplies the branch, observes fetch control.
    modport master (
        output stall_in, branch_valid, branch_type, branch_target,
        output operands_ready, inputs_not_equal,
        input  pc, flush, branch_stall, taken_count
    );

    // Resolution unit side.
    modport slave (
        input  stall_in, branch_valid, branch_type, branch_target,
        input  operands_ready, inputs_not_equal,
        output pc, flush, branch_stall, taken_count
    );
endinterface

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: resolves BEQ/BNE/J in decode, owns the fetch PC,
// waits for late operands and issues a one-cycle flush on each taken branch.
module branch_resolution_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    branch_resolution_unit_if.slave  bru
);

    typedef enum logic [1:0] {StIdle, StWait, StRedirect} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  ltype_q, ltype_d;
    logic [31:0] ltarget_q, ltarget_d;

    logic        stall_req;
    logic        resolve;
    logic        taken;
    logic [1:0]  res_type;
    logic [31:0] res_target;

    // Next-state: decode the branch (live or latched) and steer the fetch PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        count_d    = count_q;
        ltype_d    = ltype_q;
        ltarget_d  = ltarget_q;
        stall_req  = 1'b0;
        resolve    = 1'b0;
        taken      = 1'b0;
        res_type   = 2'b00;
        res_target = 32'h0;

        if (!bru.stall_in) begin
            unique case (state_q)
                StIdle: begin
                    if (bru.branch_valid && (bru.branch_type != 2'b00)) begin
                        // Jumps need no operands, so they never wait.
                        if (bru.operands_ready || (bru.branch_type == 2'b11)) begin
                            resolve    = 1'b1;
                            res_type   = bru.branch_type;
                            res_target = bru.branch_target;
                        end else begin
                            stall_req = 1'b1;
                            ltype_d   = bru.branch_type;
                            ltarget_d = bru.branch_target;
                            state_d   = StWait;
                        end
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                StWait: begin
                    if (bru.operands_ready) begin
                        resolve    = 1'b1;
                        res_type   = ltype_q;
                        res_target = ltarget_q;
                    end else begin
                        stall_req = 1'b1;
                    end
                end
                StRedirect: begin
                    // Instruction in decode is the squashed wrong-path one.
                    pc_d    = pc_q + 32'd4;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            taken = (res_type == 2'b11)
                  | ((res_type == 2'b01) & ~bru.inputs_not_equal)
                  | ((res_type == 2'b10) &  bru.inputs_not_equal);

            if (resolve) begin
                if (taken) begin
                    pc_d    = res_target & 32'hFFFF_FFFC;
                    flush_d = 1'b1;
                    state_d = StRedirect;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end else begin
                    pc_d    = pc_q + 32'd4;
                    state_d = StIdle;
                end
            end
        end
    end

    // State register with synchronous active-low reset taking priority over stall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            flush_q   <= 1'b0;
            count_q   <= 16'h0000;
            ltype_q   <= 2'b00;
            ltarget_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flush_q   <= flush_d;
            count_q   <= count_d;
            ltype_q   <= ltype_d;
            ltarget_q <= ltarget_d;
        end
    end

    assign bru.pc           = pc_q;
    assign bru.flush        = flush_q;
    assign bru.taken_count  = count_q;
    assign bru.branch_stall = stall_req & reset;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed scenarios plus a
// randomized run against a behavioural model of fetch-PC steering.
module tb_branch_resolution_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset = 1'b0;

    branch_resolution_unit_if bif ();

    branch_resolution_unit #(.RESET_PC(RESET_PC)) dut (
        .clock (clock),
        .reset (reset),
        .bru   (bif)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: expected PC, flush, count, plus "waiting on operands"
    // and "redirect pending" flags with the remembered branch.
    logic [31:0] m_pc;
    logic        m_flush;
    logic [15:0] m_cnt;
    logic        m_wait;
    logic        m_redir;
    logic [1:0]  m_wtype;
    logic [31:0] m_wtgt;

    function automatic logic is_taken(input logic [1:0] t, input logic ne);
        return (t == 2'd3) || (t == 2'd1 && !ne) || (t == 2'd2 && ne);
    endfunction

    function automatic logic exp_stall();
        if (!reset || bif.stall_in || m_redir) return 1'b0;
        if (m_wait) return !bif.operands_ready;
        return bif.branch_valid && (bif.branch_type == 2'd1 || bif.branch_type == 2'd2)
               && !bif.operands_ready;
    endfunction

    task automatic model_resolve(input logic [1:0] t, input logic [31:0] tg);
        m_wait = 1'b0;
        if (is_taken(t, bif.inputs_not_equal)) begin
            m_pc    = tg & 32'hFFFF_FFFC;
            m_flush = 1'b1;
            m_redir = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_pc    = m_pc + 32'd4;
            m_flush = 1'b0;
        end
    endtask

    task automatic model_next();
        if (!reset) begin
            m_pc = RESET_PC; m_flush = 1'b0; m_cnt = 16'h0;
            m_wait = 1'b0; m_redir = 1'b0; m_wtype = 2'd0; m_wtgt = 32'h0;
        end else if (bif.stall_in) begin
            m_flush = 1'b0;
        end else if (m_redir) begin
            m_pc = m_pc + 32'd4; m_flush = 1'b0; m_redir = 1'b0;
        end else if (m_wait) begin
            if (bif.operands_ready) model_resolve(m_wtype, m_wtgt);
            else m_flush = 1'b0;
        end else if (bif.branch_valid && bif.branch_type != 2'd0) begin
            if (bif.operands_ready || bif.branch_type == 2'd3) begin
                model_resolve(bif.branch_type, bif.branch_target);
            end else begin
                m_wait = 1'b1; m_wtype = bif.branch_type; m_wtgt = bif.branch_target;
                m_flush = 1'b0;
            end
        end else begin
            m_pc = m_pc + 32'd4; m_flush = 1'b0;
        end
    endtask

    // Apply inputs, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] tg,
                         input logic rdy, input logic ne, input logic st, input logic rst);
        reset                = rst;
        bif.branch_valid     = v;
        bif.branch_type      = t;
        bif.branch_target    = tg;
        bif.operands_ready   = rdy;
        bif.inputs_not_equal = ne;
        bif.stall_in         = st;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        model_next();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
    endtask

    task automatic test_reset();
        // Reset asserted with stall and a jump present: reset must win.
        drive(1'b1, 2'd3, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (bif.branch_stall !== 1'b0) begin
            n_bad++; $display("FAIL reset_branch_stall: got %b want 0", bif.branch_stall);
        end
        drive(1'b1, 2'd1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bif.branch_stall !== 1'b0) begin
            n_bad++; $display("FAIL reset_branch_stall_cond: got %b want 0", bif.branch_stall);
        end
        step();
        step();
        n_cmp++;
        if (bif.pc !== RESET_PC || bif.flush !== 1'b0 || bif.taken_count !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state: got pc=%h flush=%b cnt=%h want pc=%h flush=0 cnt=0",
                     bif.pc, bif.flush, bif.taken_count, RESET_PC);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
            n_cmp++;
            if (bif.pc !== 32'(4 * i) || bif.flush !== 1'b0 || bif.taken_count !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_idle_seq: got pc=%h flush=%b cnt=%h want pc=%h",
                         bif.pc, bif.flush, bif.taken_count, 32'(4 * i));
            end
        end
    endtask

    task automatic test_bne_taken();
        do_reset();
        idle_cycles(64);
        n_cmp++;
        if (bif.pc !== 32'h100) begin
            n_bad++; $display("FAIL bne_setup_pc: got %h want 00000100", bif.pc);
        end
        drive(1'b1, 2'd2, 32'h203, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (bif.pc !== 32'h200 || bif.flush !== 1'b1 || bif.taken_count !== 16'd1) begin
            n_bad++;
            $display("FAIL bne_taken: got pc=%h flush=%b cnt=%h want pc=200 flush=1 cnt=1",
                     bif.pc, bif.flush, bif.taken_count);
        end
        // Valid jump during redirect is the flushed instruction and is ignored.
        drive(1'b1, 2'd3, 32'h900, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (bif.pc !== 32'h204 || bif.flush !== 1'b0 || bif.taken_count !== 16'd1) begin
            n_bad++;
            $display("FAIL bne_redirect: got pc=%h flush=%b cnt=%h want pc=204 flush=0 cnt=1",
                     bif.pc, bif.flush, bif.taken_count);
        end
    endtask

    task automatic test_beq_not_taken();
        do_reset();
        idle_cycles(64);
        drive(1'b1, 2'd1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (bif.pc !== 32'h104 || bif.flush !== 1'b0 || bif.taken_count !== 16'd0) begin
            n_bad++;
            $display("FAIL beq_not_taken: got pc=%h flush=%b cnt=%h want pc=104 flush=0 cnt=0",
                     bif.pc, bif.flush, bif.taken_count);
        end
    endtask

    task automatic test_wait_resolve();
        do_reset();
        idle_cycles(16);
        drive(1'b1, 2'd1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bif.branch_stall !== 1'b1) begin
            n_bad++; $display("FAIL wait_stall_1: got %b want 1", bif.branch_stall);
        end
        step();
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bif.branch_stall !== 1'b1 || bif.pc !== 32'h40) begin
            n_bad++;
            $display("FAIL wait_stall_2: got stall=%b pc=%h want stall=1 pc=40",
                     bif.branch_stall, bif.pc);
        end
        step();
        n_cmp++;
        if (bif.pc !== 32'h40 || bif.flush !== 1'b0) begin
            n_bad++; $display("FAIL wait_hold: got pc=%h flush=%b want pc=40 flush=0",
                              bif.pc, bif.flush);
        end
        drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bif.branch_stall !== 1'b0) begin
            n_bad++; $display("FAIL wait_release: got %b want 0", bif.branch_stall);
        end
        step();
        n_cmp++;
        if (bif.pc !== 32'h80 || bif.flush !== 1'b1 || bif.taken_count !== 16'd1) begin
            n_bad++;
            $display("FAIL wait_taken: got pc=%h flush=%b cnt=%h want pc=80 flush=1 cnt=1",
                     bif.pc, bif.flush, bif.taken_count);
        end
        idle_cycles(1);
        n_cmp++;
        if (bif.pc !== 32'h84 || bif.flush !== 1'b0) begin
            n_bad++; $display("FAIL wait_after: got pc=%h flush=%b want pc=84 flush=0",
                              bif.pc, bif.flush);
        end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        drive(1'b1, 2'd3, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 32'h700, 1'b1, 1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (bif.branch_stall !== 1'b0) begin
                n_bad++; $display("FAIL stall_bstall: got %b want 0", bif.branch_stall);
            end
            step();
            n_cmp++;
            if (bif.pc !== 32'h500 || bif.flush !== 1'b0 || bif.taken_count !== 16'd1) begin
                n_bad++;
                $display("FAIL stall_freeze: got pc=%h flush=%b cnt=%h want pc=500 flush=0 cnt=1",
                         bif.pc, bif.flush, bif.taken_count);
            end
        end
        drive(1'b1, 2'd3, 32'h700, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (bif.pc !== 32'h504 || bif.flush !== 1'b0 || bif.taken_count !== 16'd1) begin
            n_bad++;
            $display("FAIL stall_redirect_done: got pc=%h flush=%b cnt=%h want pc=504 cnt=1",
                     bif.pc, bif.flush, bif.taken_count);
        end
        idle_cycles(1);
        n_cmp++;
        if (bif.pc !== 32'h508) begin
            n_bad++; $display("FAIL stall_back_idle: got pc=%h want 00000508", bif.pc);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        idle_cycles(4);
        drive(1'b1, 2'd2, 32'h600, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bif.pc !== RESET_PC || bif.flush !== 1'b0) begin
            n_bad++; $display("FAIL rst_wait_state: got pc=%h flush=%b want pc=%h flush=0",
                              bif.pc, bif.flush, RESET_PC);
        end
        // If the latched BNE survived, this would resolve taken.
        drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (bif.pc !== RESET_PC + 32'd4 || bif.flush !== 1'b0) begin
            n_bad++; $display("FAIL rst_wait_idle: got pc=%h flush=%b want pc=%h flush=0",
                              bif.pc, bif.flush, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 2'd3, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (bif.pc !== 32'hFFFF_FFF8) begin
            n_bad++; $display("FAIL wrap_target_mask: got %h want fffffff8", bif.pc);
        end
        idle_cycles(1);
        idle_cycles(1);
        n_cmp++;
        if (bif.pc !== 32'h0) begin
            n_bad++; $display("FAIL wrap_pc: got %h want 00000000", bif.pc);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 2'd3, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
            idle_cycles(1);
        end
        n_cmp++;
        if (bif.taken_count !== 16'hFFFF || bif.taken_count !== m_cnt) begin
            n_bad++; $display("FAIL sat_reach: got %h want ffff", bif.taken_count);
        end
        drive(1'b1, 2'd3, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (bif.taken_count !== 16'hFFFF || bif.flush !== 1'b1 || bif.pc !== 32'h1000) begin
            n_bad++;
            $display("FAIL sat_hold: got cnt=%h flush=%b pc=%h want cnt=ffff flush=1 pc=1000",
                     bif.taken_count, bif.flush, bif.pc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0);
            n_cmp++;
            if (bif.branch_stall !== exp_stall()) begin
                n_bad++; $display("FAIL rand_branch_stall[%0d]: got %b want %b",
                                  i, bif.branch_stall, exp_stall());
            end
            step();
            n_cmp++;
            if (bif.pc !== m_pc || bif.flush !== m_flush || bif.taken_count !== m_cnt) begin
                n_bad++;
                $display("FAIL rand_state[%0d]: got pc=%h flush=%b cnt=%h want pc=%h flush=%b cnt=%h",
                         i, bif.pc, bif.flush, bif.taken_count, m_pc, m_flush, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bne_taken();
        test_beq_not_taken();
        test_wait_resolve();
        test_stall_redirect();
        test_reset_in_wait();
        test_wrap();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-004 stall_in  input  1  pipeline stall; freezes the entire unit while high.
REQ-005 branch_valid  input  1  a branch/jump instruction is present in decode this cycle.
REQ-006 branch_type  input  2  01 BEQ, 10 BNE, 11 J (unconditional), 00 treated as not-a-branch.
REQ-007 branch_target  input  32  target address; bits [1:0] ignored (forced to 0).
REQ-008 operands_ready  input  1  comparator operands are valid (no outstanding hazard).
REQ-009 inputs_not_equal  input  1  result from the upstream not-equal comparator.
REQ-010 pc  output  32  current fetch address, registered.
REQ-011 flush  output  1  registered one-cycle pulse; squash the fetched wrong-path instruction.
REQ-012 branch_stall  output  1  combinational; hold decode while the branch waits for operands.
REQ-013 taken_count  output  16  registered, saturating count of taken branches/jumps.

Function
REQ-014 States: IDLE, WAIT, REDIRECT; encoding is implementation choice.
REQ-015 taken = (type==11) | (type==01 & ~inputs_not_equal) | (type==10 & inputs_not_equal).
REQ-016 Any cycle with stall_in=1 and reset deasserted: pc, state, latched branch info, taken_count hold; flush<=0; branch_stall=0.
REQ-017 IDLE, no valid branch (branch_valid=0 or type=00): pc<=pc+4, stay IDLE.
REQ-018 IDLE, valid branch, operands_ready=1 (or type=11): resolve same cycle; taken -> pc<=target, flush<=1, go REDIRECT; not taken -> pc<=pc+4, stay IDLE.
REQ-019 IDLE, valid conditional branch, operands_ready=0: branch_stall=1, latch type and target, pc holds, go WAIT.
REQ-020 WAIT: branch_valid ignored; branch_stall = ~operands_ready; on operands_ready=1 resolve with latched type/target per REQ-018, using current inputs_not_equal.
REQ-021 REDIRECT: lasts exactly one unstalled cycle; branch_valid ignored (instruction is being flushed); pc<=pc+4, flush<=0, go IDLE.
REQ-022 flush SHALL be high for exactly one cycle following each taken resolution and low otherwise.
REQ-023 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 taken_count increments by 1 on each taken resolution; holds at 16'hFFFF.
REQ-025 Latency: branch decision to pc update = 1 clock; no additional bubbles beyond REDIRECT.

Reset
REQ-026 reset=0 at a rising edge: pc<=RESET_PC, state<=IDLE, flush<=0, taken_count<=0, latched info cleared; reset overrides stall_in and any in-flight branch (including WAIT/REDIRECT).
REQ-027 branch_stall SHALL be 0 while reset is asserted.

Verification
REQ-028 Reset then 3 idle cycles -> pc = 0, 4, 8, 12; flush=0; taken_count=0.
REQ-029 pc=0x100, BNE valid, ready, not_equal=1, target 0x203 -> next pc=0x200, flush=1 one cycle, next pc=0x204, taken_count=1.
REQ-030 pc=0x100, BEQ, ready, not_equal=1 -> pc=0x104, flush=0, taken_count unchanged.
REQ-031 pc=0x40, BEQ, operands_ready=0 for 2 cycles then 1 with not_equal=0, target 0x80 -> branch_stall=1 two cycles, pc holds 0x40, then pc=0x80, flush pulse.
REQ-032 stall_in=1 during REDIRECT for 3 cycles -> pc, state, taken_count frozen, flush low after first cycle; REDIRECT completes after stall drops; separately, reset asserted in WAIT -> pc=RESET_PC, IDLE, no flush.
REQ-033 pc=0xFFFF_FFFC no branch -> pc=0; taken_count preset to 0xFFFF via 65535 taken jumps -> remains 0xFFFF after another J.
